// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and helpers for the UART transmit path.
//   tx_state_t : frame sequencer states
//   PARITY_*   : encoding of the parity_odd configuration bit
//   clamp_len  : maps a runtime data length onto 1..max_len
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Out-of-range lengths (0 or above max_len) fall back to the full width.
  function automatic int clamp_len(input int len, input int max_len);
    int r;
    r = len;
    if (len == 0 || len > max_len) r = max_len;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// uart_tx_shift
//   Loadable data shift register for the UART transmitter, with LSB- or
//   MSB-first direction and a running parity of the bits shifted out.
// Ports
//   UCLK, reset : clock, async active-high reset
//   load        : capture data/len/msb_first, clear parity
//   shift       : consume the current head bit (folded into parity)
//   msb_first   : direction captured on load
//   data, len   : word and clamped data length (1..DATA_WIDTH)
//   head        : bit that goes on the line next
//   parity      : XOR of all bits consumed since load
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  msb_first,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_W-1:0]      len,
  output logic                  head,
  output logic                  parity
);

  logic [DATA_WIDTH-1:0] sr;
  logic                  msb_r;

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      sr     <= '0;
      msb_r  <= 1'b0;
      parity <= 1'b0;
    end else if (load) begin
      msb_r  <= msb_first;
      parity <= 1'b0;
      // MSB-first: left-align the len-bit field so the head is always the top bit.
      sr     <= msb_first ? (data << (DATA_WIDTH - int'(len))) : data;
    end else if (shift) begin
      parity <= parity ^ head;
      sr     <= msb_r ? (sr << 1) : (sr >> 1);
    end
  end

  assign head = msb_r ? sr[DATA_WIDTH-1] : sr[0];

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   UART transmit framer: accepts a word on tx_valid/tx_ready and sends
//   start, 1..DATA_WIDTH data bits, optional parity and 1 or 2 stop bits,
//   one bit per baud_tick.
// Ports
//   UCLK, reset          : clock, async active-high reset
//   tx_data, tx_valid    : word and its valid strobe
//   tx_ready             : high only while idle
//   data_len             : data bits per frame (0 or >DATA_WIDTH => DATA_WIDTH)
//   parity_en/parity_odd : parity enable and sense
//   two_stop, msb_first  : stop-bit count and bit order
//   baud_tick            : end of the current bit period
//   baud_sync            : one-cycle pulse after accept to realign the baud generator
//   serial_out           : TX line (idle high, registered)
//   tx_busy, tx_done     : frame in progress / one-cycle end-of-frame pulse
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  msb_first,
  input  logic                  baud_tick,
  output logic                  baud_sync,
  output logic                  serial_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  tx_state_t        state, state_nx;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_nx;
  logic [LEN_W-1:0] len_r, len_c;
  logic             par_en_r, par_odd_r, two_stop_r;
  logic             serial_nx, sync_nx, done_nx;
  logic             load, shift;
  logic             head, parity_acc;

  assign len_c    = LEN_W'(clamp_len(int'(data_len), DATA_WIDTH));
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  uart_tx_shift #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_W     (LEN_W)
  ) u_shift (
    .UCLK     (UCLK),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .msb_first(msb_first),
    .data     (tx_data),
    .len      (len_c),
    .head     (head),
    .parity   (parity_acc)
  );

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      len_r      <= '0;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      two_stop_r <= 1'b0;
      serial_out <= 1'b1;
      baud_sync  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      serial_out <= serial_nx;
      baud_sync  <= sync_nx;
      tx_done    <= done_nx;
      if (load) begin
        len_r      <= len_c;
        par_en_r   <= parity_en;
        par_odd_r  <= parity_odd;
        two_stop_r <= two_stop;
      end
    end
  end

  // A data bit is shifted out of u_shift as it is placed on the line, so by
  // the final data tick parity_acc already covers all len bits.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    serial_nx  = serial_out;
    sync_nx    = 1'b0;
    done_nx    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        serial_nx = 1'b1;
        if (tx_valid) begin
          load       = 1'b1;
          state_nx   = START;
          serial_nx  = 1'b0;
          sync_nx    = 1'b1;
          bit_cnt_nx = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_nx  = DATA;
          serial_nx = head;
          shift     = 1'b1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == len_r - LEN_W'(1)) begin
            if (par_en_r) begin
              state_nx  = PARITY;
              serial_nx = parity_acc ^ (par_odd_r == PARITY_ODD);
            end else begin
              state_nx  = STOP1;
              serial_nx = 1'b1;
            end
          end else begin
            serial_nx  = head;
            shift      = 1'b1;
            bit_cnt_nx = bit_cnt + LEN_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_nx  = STOP1;
          serial_nx = 1'b1;
        end
      end
      STOP1: begin
        serial_nx = 1'b1;
        if (baud_tick) begin
          if (two_stop_r) begin
            state_nx = STOP2;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      STOP2: begin
        serial_nx = 1'b1;
        if (baud_tick) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx  = IDLE;
        serial_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Directed bench for uart_tx_framer: frame contents for several formats,
//   handshake, back-to-back transfer and mid-frame reset.
module tb_uart_tx_framer;

  localparam int DW = 9;
  localparam int LW = 4;

  logic          UCLK = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LW-1:0] data_len;
  logic          parity_en, parity_odd, two_stop, msb_first;
  logic          baud_tick;
  logic          baud_sync;
  logic          serial_out;
  logic          tx_busy;
  logic          tx_done;

  int checks   = 0;
  int errors   = 0;
  int sync_cnt = 0;

  uart_tx_framer #(.DATA_WIDTH(DW)) dut (
    .UCLK      (UCLK),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .data_len  (data_len),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
    .msb_first (msb_first),
    .baud_tick (baud_tick),
    .baud_sync (baud_sync),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 UCLK = ~UCLK;

  always @(posedge UCLK) if (baud_sync === 1'b1) sync_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line values in time order, e.g. "0101001011" -> bit k = k-th bit period.
  function automatic logic [15:0] bits(input string s);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == 8'h31);
    return r;
  endfunction

  task automatic drive_cfg(input logic [DW-1:0] d, input logic [LW-1:0] len,
                           input logic pe, input logic po, input logic ts, input logic msb);
    tx_data    = d;
    data_len   = len;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    msb_first  = msb;
    tx_valid   = 1'b1;
  endtask

  task automatic do_tick();
    repeat (15) @(negedge UCLK);
    baud_tick = 1'b1;
    @(negedge UCLK);
    baud_tick = 1'b0;
  endtask

  // Called at a negedge with the word already presented and the DUT idle.
  // Returns at the negedge where tx_done must be high.
  task automatic check_frame(input string tag, input logic [15:0] exp, input int n,
                             input bit hold, input bit scramble);
    int s0;
    s0 = sync_cnt;
    chk({tag, " ready_before"}, 16'(tx_ready), 16'd1);
    @(negedge UCLK);
    if (!hold) tx_valid = 1'b0;
    chk({tag, " sync_pulse"}, 16'(baud_sync), 16'd1);
    chk({tag, " busy"}, 16'(tx_busy), 16'd1);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s bit%0d_early", tag, k), 16'(serial_out), 16'(exp[k]));
      repeat (8) @(negedge UCLK);
      if (scramble && k == 2) begin
        tx_data    = ~tx_data;
        data_len   = 4'd3;
        parity_en  = ~parity_en;
        parity_odd = ~parity_odd;
        two_stop   = ~two_stop;
        msb_first  = ~msb_first;
      end
      chk($sformatf("%s bit%0d_mid", tag, k), 16'(serial_out), 16'(exp[k]));
      chk($sformatf("%s ready_low%0d", tag, k), 16'(tx_ready), 16'd0);
      chk($sformatf("%s sync_low%0d", tag, k), 16'(baud_sync), 16'd0);
      repeat (7) @(negedge UCLK);
      baud_tick = 1'b1;
      @(negedge UCLK);
      baud_tick = 1'b0;
    end
    chk({tag, " done"}, 16'(tx_done), 16'd1);
    chk({tag, " ready_after"}, 16'(tx_ready), 16'd1);
    chk({tag, " busy_after"}, 16'(tx_busy), 16'd0);
    chk({tag, " line_after"}, 16'(serial_out), 16'd1);
    chk({tag, " sync_count"}, 16'(sync_cnt), 16'(s0 + 1));
  endtask

  task automatic idle_gap(input string tag);
    @(negedge UCLK);
    chk({tag, " done_drop"}, 16'(tx_done), 16'd0);
    chk({tag, " idle_line"}, 16'(serial_out), 16'd1);
  endtask

  initial begin
    reset      = 1'b1;
    tx_data    = '0;
    tx_valid   = 1'b0;
    data_len   = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    msb_first  = 1'b0;
    baud_tick  = 1'b0;
    repeat (3) @(negedge UCLK);
    chk("rst line", 16'(serial_out), 16'd1);
    chk("rst ready", 16'(tx_ready), 16'd1);
    chk("rst busy", 16'(tx_busy), 16'd0);
    chk("rst done", 16'(tx_done), 16'd0);
    chk("rst sync", 16'(baud_sync), 16'd0);
    reset = 1'b0;
    @(negedge UCLK);

    // Tick while idle has no effect.
    baud_tick = 1'b1;
    @(negedge UCLK);
    baud_tick = 1'b0;
    @(negedge UCLK);
    chk("idle_tick line", 16'(serial_out), 16'd1);
    chk("idle_tick busy", 16'(tx_busy), 16'd0);

    drive_cfg(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("8n1", bits("0101001011"), 10, 1'b0, 1'b0);
    idle_gap("8n1");

    drive_cfg(9'h0A5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("8e1", bits("01010010101"), 11, 1'b0, 1'b0);
    idle_gap("8e1");

    // Odd parity, with every config input scrambled mid-frame.
    drive_cfg(9'h0A5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("8o1_scr", bits("01010010111"), 11, 1'b0, 1'b1);
    idle_gap("8o1_scr");

    drive_cfg(9'h041, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frame("7e2", bits("01000001011"), 11, 1'b0, 1'b0);
    idle_gap("7e2");

    drive_cfg(9'h080, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    check_frame("msb8", bits("0100000001"), 10, 1'b0, 1'b0);
    idle_gap("msb8");

    // Only the low 5 bits (00110) go out, MSB first, odd parity.
    drive_cfg(9'h1E6, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frame("msb5o", bits("00011011"), 8, 1'b0, 1'b0);
    idle_gap("msb5o");

    // data_len=0 selects all 9 bits; bit 8 is 0 so it differs from the stop.
    drive_cfg(9'h0A5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("len0", bits("01010010101"), 11, 1'b0, 1'b0);
    idle_gap("len0");

    // Back-to-back with tx_valid held throughout.
    drive_cfg(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("b2b_a", bits("0101010101"), 10, 1'b1, 1'b0);
    drive_cfg(9'h00F, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("b2b_b", bits("0111100001"), 10, 1'b0, 1'b0);
    idle_gap("b2b_b");

    // Reset during data bit 3.
    drive_cfg(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge UCLK);
    tx_valid = 1'b0;
    chk("rst_mid start", 16'(serial_out), 16'd0);
    do_tick();
    do_tick();
    do_tick();
    chk("rst_mid bit2", 16'(serial_out), 16'd1);
    do_tick();
    repeat (5) @(negedge UCLK);
    chk("rst_mid bit3", 16'(serial_out), 16'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid line_now", 16'(serial_out), 16'd1);
    chk("rst_mid ready", 16'(tx_ready), 16'd1);
    chk("rst_mid busy", 16'(tx_busy), 16'd0);
    @(negedge UCLK);
    reset = 1'b0;
    @(negedge UCLK);
    chk("post_rst ready", 16'(tx_ready), 16'd1);
    chk("post_rst line", 16'(serial_out), 16'd1);
    drive_cfg(9'h00F, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("post_rst", bits("01111000001"), 11, 1'b0, 1'b0);
    idle_gap("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
